// File: rtl/hazard_scoreboard.sv
// Destination-register scoreboard for ID/EX, EX/MEM and MEM/WB, with load-use and MDU stall generation.
// Optional MDU occupancy tracking is enabled by defining HAZARD_SCOREBOARD_MDU_EN.
module hazard_scoreboard #(
  parameter int unsigned MDU_LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        id_is_mdu,
  input  logic        flush,
  output logic        stall,
  output logic        mdu_busy,
  output logic [4:0]  ex_rd,
  output logic        ex_reg_write,
  output logic [4:0]  mem_rd,
  output logic        mem_reg_write,
  output logic [31:0] stall_count
);

  logic        idex_valid;
  logic [4:0]  idex_rd;
  logic        idex_we;
  logic        idex_mr;
  logic [4:0]  exm_rd;
  logic        exm_we;
  logic [4:0]  mwb_rd;
  logic        mwb_we;
  logic [31:0] stall_cnt;
  logic        load_use;

  // idex_we is never set for rd=0, so x0 cannot create a load-use hazard.
  assign load_use = id_valid && idex_valid && idex_mr && idex_we &&
                    ((idex_rd == id_rs1) || (idex_rd == id_rs2));

  assign stall = (load_use || mdu_busy) && !flush;

`ifdef HAZARD_SCOREBOARD_MDU_EN
  localparam logic [3:0] MDU_LOAD = 4'(MDU_LATENCY - 1);
  logic [3:0] mdu_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mdu_cnt <= 4'd0;
    end else if (flush) begin
      mdu_cnt <= 4'd0;
    end else if (mdu_busy) begin
      mdu_cnt <= mdu_cnt - 4'd1;
    end else if (!load_use && id_valid && id_is_mdu) begin
      mdu_cnt <= MDU_LOAD;
    end
  end

  assign mdu_busy = (mdu_cnt != 4'd0);
`else
  logic unused_mdu;
  assign unused_mdu = ^{id_is_mdu, 4'(MDU_LATENCY)};
  assign mdu_busy   = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex_valid <= 1'b0;
      idex_rd    <= 5'd0;
      idex_we    <= 1'b0;
      idex_mr    <= 1'b0;
      exm_rd     <= 5'd0;
      exm_we     <= 1'b0;
      mwb_rd     <= 5'd0;
      mwb_we     <= 1'b0;
    end else begin
      mwb_rd <= exm_rd;
      mwb_we <= exm_we;
      if (flush || (!mdu_busy && load_use)) begin
        idex_valid <= 1'b0;
        idex_rd    <= 5'd0;
        idex_we    <= 1'b0;
        idex_mr    <= 1'b0;
        exm_rd     <= idex_rd;
        exm_we     <= idex_we;
      end else if (mdu_busy) begin
        // MDU op stays in ID/EX; downstream sees bubbles until it completes.
        exm_rd <= 5'd0;
        exm_we <= 1'b0;
      end else begin
        exm_rd <= idex_rd;
        exm_we <= idex_we;
        if (id_valid) begin
          idex_valid <= 1'b1;
          idex_rd    <= id_rd;
          idex_we    <= id_reg_write && (id_rd != 5'd0);
          idex_mr    <= id_mem_read;
        end else begin
          idex_valid <= 1'b0;
          idex_rd    <= 5'd0;
          idex_we    <= 1'b0;
          idex_mr    <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= 32'd0;
    end else if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign ex_rd         = exm_rd;
  assign ex_reg_write  = exm_we;
  assign mem_rd        = mwb_rd;
  assign mem_reg_write = mwb_we;
  assign stall_count   = stall_cnt;

endmodule
